// File: rtl/store_datapath.sv
// Squeeze-side output stage: unloads Keccak rate blocks as W-bit big-endian words.
// Optional data_out_keep port is enabled with `define SHAKE_OUT_KEEP_EN.
package keccak_pkg;
    localparam int          w                 = 64;
    localparam int          RATE_SHAKE128     = 1344;
    localparam logic [1:0]  SHAKE128_MODE_VEC = 2'b10;
    localparam logic [1:0]  SHAKE256_MODE_VEC = 2'b11;
endpackage

// Purpose: PISO word unloader between the Keccak squeeze and a valid/ready sink.
// Latency: first word one cycle after block capture, then one word per accepted cycle.
// Backpressure: outputs hold while data_out_ready=0; a new block is requested only via state_ready.
module store_datapath
    import keccak_pkg::*;
#(
    parameter int W    = keccak_pkg::w,
    parameter int RATE = keccak_pkg::RATE_SHAKE128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     output_size,
    input  logic [1:0]      operation_mode,
    input  logic            state_valid,
    input  logic [RATE-1:0] state_in,
    output logic            state_ready,
    output logic [W-1:0]    data_out,
    output logic            data_out_valid,
    input  logic            data_out_ready,
    output logic            last_out,
    output logic            busy,
    output logic            done
`ifdef SHAKE_OUT_KEEP_EN
    ,
    output logic [W/8-1:0]  data_out_keep
`endif
);

    localparam int          BPW   = W / 8;
    localparam logic [28:0] BPW29 = 29'(BPW);

    typedef enum logic [1:0] {IDLE, WAIT_BLOCK, SHIFT} state_t;

    state_t          state_q;
    logic [RATE-1:0] piso_q;
    logic [4:0]      cnt_q;
    logic [28:0]     rem_q;
    logic [1:0]      mode_q;
    logic            done_q;

    logic [RATE-1:0] piso_d;
    logic [4:0]      cnt_d;
    logic [28:0]     rem_d;
    logic [4:0]      depth_m1;
    logic            last_w;
    logic            is_shift;
    logic [W-1:0]    swapped;
    logic [W-1:0]    masked;
    logic [BPW-1:0]  keep;
    logic            unused_size_bits;

    assign unused_size_bits = ^output_size[2:0];

    always_comb begin
        case (mode_q)
            SHAKE256_MODE_VEC: depth_m1 = 5'd16;
            SHAKE128_MODE_VEC: depth_m1 = 5'd20;
            default:           depth_m1 = 5'd20;
        endcase
    end

    assign is_shift = (state_q == SHIFT);
    assign last_w   = (rem_q <= BPW29);
    assign rem_d    = (rem_q > BPW29) ? (rem_q - BPW29) : '0;
    assign cnt_d    = cnt_q + 5'd1;
    assign piso_d   = piso_q >> W;

    // Byte j counted from the MSB is kept while j is below the remaining byte count.
    always_comb begin
        swapped = '0;
        masked  = '0;
        keep    = '0;
        for (int b = 0; b < BPW; b++) begin
            swapped[8*b +: 8] = piso_q[W-8-8*b +: 8];
        end
        for (int j = 0; j < BPW; j++) begin
            keep[BPW-1-j]           = (29'(j) < rem_q);
            masked[W-8-8*j +: 8]    = swapped[W-8-8*j +: 8] & {8{keep[BPW-1-j]}};
        end
    end

    assign state_ready    = (state_q == WAIT_BLOCK);
    assign data_out_valid = is_shift;
    assign data_out       = is_shift ? masked : '0;
    assign last_out       = is_shift & last_w;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
`ifdef SHAKE_OUT_KEEP_EN
    assign data_out_keep  = is_shift ? keep : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            piso_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (output_size[31:3] != '0) begin
                            rem_q   <= output_size[31:3];
                            mode_q  <= operation_mode;
                            state_q <= WAIT_BLOCK;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                WAIT_BLOCK: begin
                    if (state_valid) begin
                        piso_q  <= state_in;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (data_out_ready) begin
                        rem_q  <= rem_d;
                        cnt_q  <= cnt_d;
                        piso_q <= piso_d;
                        if (last_w) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else if (cnt_q == depth_m1) begin
                            state_q <= WAIT_BLOCK;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_datapath.sv
// Scoreboard bench for store_datapath: directed requests, stall, zero-length and reset-abort cases.
module tb_store_datapath;
    import keccak_pkg::*;

    localparam int W    = 64;
    localparam int RATE = RATE_SHAKE128;

    logic            clk;
    logic            rst;
    logic            start;
    logic [31:0]     output_size;
    logic [1:0]      operation_mode;
    logic            state_valid;
    logic [RATE-1:0] state_in;
    logic            state_ready;
    logic [W-1:0]    data_out;
    logic            data_out_valid;
    logic            data_out_ready;
    logic            last_out;
    logic            busy;
    logic            done;
`ifdef SHAKE_OUT_KEEP_EN
    logic [7:0]      data_out_keep;
`endif

    store_datapath #(.W(W), .RATE(RATE)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .output_size    (output_size),
        .operation_mode (operation_mode),
        .state_valid    (state_valid),
        .state_in       (state_in),
        .state_ready    (state_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .last_out       (last_out),
        .busy           (busy),
        .done           (done)
`ifdef SHAKE_OUT_KEEP_EN
        ,
        .data_out_keep  (data_out_keep)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] dat;
        logic        last;
        logic [7:0]  keep;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   acc_cnt  = 0;
    int   done_cyc = 0;
    int   hs_cnt   = 0;
    int   blk      = 0;
    int   g_d0, g_h0, g_a0, g_nw;

    function automatic logic [63:0] lane_val(input int b, input int i);
        logic [3:0] bb;
        logic [7:0] ii;
        bb = 4'(b);
        ii = 8'(i);
        return {4'hA, bb, ii, 48'h0011_2233_4455};
    endfunction

    function automatic logic [63:0] bswap(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 8; k++) y[8*k +: 8] = x[56-8*k +: 8];
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic l, input logic [7:0] k);
        exp_t e;
        e.dat = d; e.last = l; e.keep = k;
        sb.push_back(e);
    endtask

    // Reference: word k is lane (k mod depth) of block (base + k / depth); last word MSB-masked.
    task automatic push_model(input logic [1:0] mode, input logic [31:0] size);
        int nbytes, nwords, depth, vb;
        logic [7:0]  kp;
        logic [63:0] m;
        nbytes = int'(size[31:3]);
        nwords = (nbytes + 7) / 8;
        depth  = (mode == SHAKE256_MODE_VEC) ? 17 : 21;
        for (int k = 0; k < nwords; k++) begin
            vb = (k == nwords - 1) ? nbytes - 8 * k : 8;
            kp = 8'hFF << (8 - vb);
            for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{kp[j]}};
            push(bswap(lane_val(blk + k / depth, k % depth)) & m, k == nwords - 1, kp);
        end
    endtask

    task automatic go(input logic [1:0] mode, input logic [31:0] size);
        g_d0 = done_cyc; g_h0 = hs_cnt; g_a0 = acc_cnt;
        g_nw = (int'(size[31:3]) + 7) / 8;
        start = 1'b1; output_size = size; operation_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_req(input string name, input int exp_hs);
        int cyc;
        cyc = 0;
        while (done_cyc == g_d0 && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk({name, "_done_seen"}, 64'(done_cyc != g_d0), 64'd1);
        @(negedge clk); #1;
        chk({name, "_done_width"}, 64'(done_cyc - g_d0), 64'd1);
        chk({name, "_words"}, 64'(acc_cnt - g_a0), 64'(g_nw));
        chk({name, "_blocks"}, 64'(hs_cnt - g_h0), 64'(exp_hs));
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Block source: always offers the next block; advances after each handshake.
    initial begin
        logic hs;
        state_valid = 1'b1;
        forever begin
            for (int i = 0; i < 21; i++) state_in[64*i +: 64] = lane_val(blk, i);
            @(negedge clk);
            hs = state_valid && state_ready;
            @(posedge clk); #1;
            if (hs) begin
                blk++;
                hs_cnt++;
            end
        end
    end

    // Monitor: pops and compares every word the sink accepts.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (done) done_cyc++;
            if (data_out_valid && data_out_ready) begin
                acc_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got dat=%h last=%b want none", data_out, last_out);
                end else begin
                    e  = sb.pop_front();
                    ok = (data_out === e.dat) && (last_out === e.last);
`ifdef SHAKE_OUT_KEEP_EN
                    ok = ok && (data_out_keep === e.keep);
                    if (!ok) begin
                        errors++;
                        $display("FAIL word%0d: got dat=%h last=%b keep=%h want dat=%h last=%b keep=%h",
                                 acc_cnt, data_out, last_out, data_out_keep, e.dat, e.last, e.keep);
                    end
`else
                    if (!ok) begin
                        errors++;
                        $display("FAIL word%0d: got dat=%h last=%b want dat=%h last=%b",
                                 acc_cnt, data_out, last_out, e.dat, e.last);
                    end
`endif
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] snap_d;
        logic        snap_l;
        int          cyc, nv, nb;
        logic [63:0] outs;

        rst = 1'b0; start = 1'b0; output_size = '0; operation_mode = '0; data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outs = {data_out[31:0], 26'd0, data_out_valid, last_out, busy, done, state_ready, 1'b0};
`ifdef SHAKE_OUT_KEEP_EN
        outs[0] = |data_out_keep;
`endif
        chk("reset_outputs", outs, 64'd0);
        chk("reset_data", data_out, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // SHAKE128, 256 bits: four full lanes of block 0
        push(64'h55443322_110000A0, 1'b0, 8'hFF);
        push(64'h55443322_110001A0, 1'b0, 8'hFF);
        push(64'h55443322_110002A0, 1'b0, 8'hFF);
        push(64'h55443322_110003A0, 1'b1, 8'hFF);
        go(SHAKE128_MODE_VEC, 32'd256);
        finish_req("s128_256", 1);

        // SHAKE128, 104 bits: 13 bytes, second word keeps 5 upper bytes of lane 1
        push(64'h55443322_110000A1, 1'b0, 8'hFF);
        push(64'h55443322_11000000, 1'b1, 8'hF8);
        go(SHAKE128_MODE_VEC, 32'd104);
        finish_req("s128_104", 1);

        // SHAKE256, 1152 bits across two blocks, with a 5-cycle stall after word 3
        push_model(SHAKE256_MODE_VEC, 32'd1152);
        go(SHAKE256_MODE_VEC, 32'd1152);
        cyc = 0;
        while (acc_cnt < g_a0 + 3 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("stall_reach", 64'(acc_cnt >= g_a0 + 3), 64'd1);
        @(posedge clk); #1;
        data_out_ready = 1'b0;
        snap_d = data_out;
        snap_l = last_out;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_hold", {data_out[61:0], data_out_valid, last_out},
                {snap_d[61:0], 1'b1, snap_l});
        end
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        finish_req("s256_1152", 2);

        // Zero-length request: done only, no words, never busy
        g_d0 = done_cyc;
        start = 1'b1; output_size = 32'd7; operation_mode = SHAKE128_MODE_VEC;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0; nb = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (data_out_valid) nv++;
            if (busy) nb++;
        end
        #1;
        chk("zero_done_cycles", 64'(done_cyc - g_d0), 64'd1);
        chk("zero_valid", 64'(nv), 64'd0);
        chk("zero_busy", 64'(nb), 64'd0);

        // Reset in SHIFT after word 2 aborts the request without a done pulse
        push_model(SHAKE128_MODE_VEC, 32'd512);
        go(SHAKE128_MODE_VEC, 32'd512);
        cyc = 0;
        while (acc_cnt < g_a0 + 2 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("abort_reach", 64'(acc_cnt >= g_a0 + 2), 64'd1);
        @(posedge clk); #1;
        data_out_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        outs = {data_out[31:0], 26'd0, data_out_valid, last_out, busy, done, state_ready, 1'b0};
`ifdef SHAKE_OUT_KEEP_EN
        outs[0] = |data_out_keep;
`endif
        chk("abort_outputs", outs, 64'd0);
        chk("abort_data", data_out, 64'd0);
        rst = 1'b1;
        data_out_ready = 1'b1;
        sb.delete();
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(done_cyc - g_d0), 64'd0);

        // Fresh request after the abort starts from word 0 of a new block
        push_model(SHAKE128_MODE_VEC, 32'd256);
        go(SHAKE128_MODE_VEC, 32'd256);
        finish_req("after_abort", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
